// File: rtl/cnt_match_seq_pkg.sv
// Shared types and constants for the counter/compare sequencer.
package cnt_match_seq_pkg;

  // Width of one counter slice.
  localparam int unsigned NIBBLE = 4;

  // Sequencer states. The encodings are fixed so the state can be read directly off a bus.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARM   = 3'd1,
    S_RUN   = 3'd2,
    S_MATCH = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  // The counter is built from whole nibble slices, so the width has to split evenly.
  function automatic bit width_ok(input int unsigned w);
    return (w != 0) && ((w % NIBBLE) == 0);
  endfunction

endpackage

// File: rtl/nibble_cnt.sv
// One 4-bit slice of the cascaded up-counter.
// The slice counts only when the chain carry reaches it. It passes the carry on
// when it is about to wrap from 0xF.
module nibble_cnt
  import cnt_match_seq_pkg::*;
(
  input  logic              CK,
  input  logic              RST,
  input  logic              CLR,
  input  logic              EN,
  input  logic              CI,
  output logic [NIBBLE-1:0] Q,
  output logic              CO
);

  // Slice register: reset and clear win over increment.
  always_ff @(posedge CK) begin
    if (RST || CLR) begin
      Q <= '0;
    end else if (EN && CI) begin
      Q <= Q + 4'd1;
    end
  end

  assign CO = CI & (Q == '1);

endmodule

// File: rtl/cnt_match_seq.sv
// Sequencer for the nibble-cascaded counter/constant-compare datapath.
// It captures a compare value and a repeat count on START, then counts up from zero
// until the count equals the compare value. Each equality gives a one-cycle Z_PULSE.
// This repeats CFG_RPT+1 times, and DONE is then held until ACK.
module cnt_match_seq
  import cnt_match_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned RPT_W = 4
) (
  input  logic             CK,
  input  logic             RST,
  input  logic             START,
  input  logic             STOP,
  input  logic             ACK,
  input  logic [WIDTH-1:0] CFG_VAL,
  input  logic [RPT_W-1:0] CFG_RPT,
  output logic [WIDTH-1:0] CNT,
  output logic             CNT_EN,
  output logic             Z_PULSE,
  output logic             BUSY,
  output logic             DONE,
  output logic [RPT_W-1:0] RPT_LEFT
);

  localparam bit          WIDTH_OK = width_ok(WIDTH);
  localparam int unsigned SLICES   = WIDTH / NIBBLE;

  if (!WIDTH_OK) begin : g_width_check
    $error("cnt_match_seq: WIDTH must be a non-zero multiple of 4");
  end

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] cmp_reg;
  logic             hit;
  logic             cnt_en;
  logic             clr;
  logic [SLICES:0]  carry;
  logic             carry_out_unused;

  assign hit = (CNT == cmp_reg);

  // Count enable and counter clear, decoded from the current state and the abort/match priority.
  always_comb begin
    cnt_en = 1'b0;
    clr    = 1'b0;
    case (state)
      S_IDLE:  clr    = START;
      S_RUN:   cnt_en = !STOP && !hit;
      S_MATCH: clr    = 1'b1;
      default: ;
    endcase
  end

  assign CNT_EN = cnt_en;

  // Next-state decode. In RUN the priority is STOP, then match, then count.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (START) state_nxt = S_ARM;
      S_ARM:   state_nxt = STOP ? S_IDLE : S_RUN;
      S_RUN: begin
        if (STOP)     state_nxt = S_IDLE;
        else if (hit) state_nxt = S_MATCH;
      end
      S_MATCH: begin
        if (STOP)                state_nxt = S_IDLE;
        else if (RPT_LEFT == '0) state_nxt = S_DONE;
        else                     state_nxt = S_RUN;
      end
      S_DONE:  if (ACK) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State, captured configuration and status outputs.
  // The status flags are registered from the next state, so each one lines up with the state it reports.
  always_ff @(posedge CK) begin
    if (RST) begin
      state    <= S_IDLE;
      cmp_reg  <= '0;
      RPT_LEFT <= '0;
      BUSY     <= 1'b0;
      DONE     <= 1'b0;
      Z_PULSE  <= 1'b0;
    end else begin
      state   <= state_nxt;
      BUSY    <= (state_nxt == S_ARM) || (state_nxt == S_RUN) || (state_nxt == S_MATCH);
      DONE    <= (state_nxt == S_DONE);
      Z_PULSE <= (state_nxt == S_MATCH);
      if (state == S_IDLE && START) begin
        cmp_reg  <= CFG_VAL;
        RPT_LEFT <= CFG_RPT;
      end else if (state == S_MATCH && !STOP && RPT_LEFT != '0) begin
        RPT_LEFT <= RPT_LEFT - RPT_W'(1);
      end
    end
  end

  // Ripple the carry through the slices. Slice 0 is fed directly by the count enable.
  assign carry[0] = cnt_en;

  for (genvar k = 0; k < SLICES; k++) begin : g_slice
    nibble_cnt u_nib (
      .CK  (CK),
      .RST (RST),
      .CLR (clr),
      .EN  (cnt_en),
      .CI  (carry[k]),
      .Q   (CNT[k*NIBBLE +: NIBBLE]),
      .CO  (carry[k+1])
    );
  end

  // The carry out of the top slice has no consumer: a run always matches before the counter wraps.
  assign carry_out_unused = carry[SLICES];

endmodule

// File: doc/cnt_match_seq.md
Name: cnt_match_seq

Overview:
- Sequencer for the nibble-cascaded counter/constant-compare datapath used in the ISCAS-class sequential tests.
- Takes a START request, loads a compare value and a repeat count, then runs a WIDTH-bit up-counter until it equals the compare value.
- Emits a one-cycle match pulse on each equality, repeats RPT+1 times, then holds DONE until acknowledged.
- Sits between a host/test driver and the counter datapath; it owns the count enable, the clear and the compare constant.

Parameters:
- WIDTH, 16, counter and compare width; must be a multiple of 4.
- RPT_W, 4, width of the repeat-count field.

Ports:
- CK  input  1  clock; all state updates on its rising edge.
- RST  input  1  synchronous active-high reset, sampled on the rising edge of CK.
- START  input  1  request; sampled only in IDLE.
- STOP  input  1  abort request; honoured in ARM, RUN and MATCH.
- ACK  input  1  acknowledges DONE.
- CFG_VAL  input  WIDTH  compare value; captured when START is accepted.
- CFG_RPT  input  RPT_W  extra repetitions; captured when START is accepted.
- CNT  output  WIDTH  current counter value.
- CNT_EN  output  1  high in cycles where CNT increments (the datapath's P_0 equivalent).
- Z_PULSE  output  1  one-cycle match pulse.
- BUSY  output  1  high in ARM, RUN and MATCH.
- DONE  output  1  held high in DONE state.
- RPT_LEFT  output  RPT_W  remaining repetitions.

Behaviour:
- Reset (RST=1 on an edge, from any state, including mid-run):
  - state goes to IDLE;
  - CNT, cmp_reg, RPT_LEFT, Z_PULSE, BUSY, DONE and CNT_EN all go to 0;
  - RST has priority over every other input.
- State machine, registered state:
  - IDLE: if START=1, capture CFG_VAL into cmp_reg and CFG_RPT into RPT_LEFT, clear CNT, go to ARM. Otherwise stay.
  - ARM: one cycle with no counting. If STOP=1, go to IDLE; else go to RUN.
  - RUN: priority is STOP, then match, then count.
    - STOP=1: go to IDLE; CNT is held (not cleared), so the abort point stays observable.
    - CNT==cmp_reg: go to MATCH; CNT does not increment this cycle.
    - otherwise: CNT <= CNT+1, modulo 2^WIDTH; CNT_EN=1 only in these cycles.
  - MATCH: Z_PULSE=1 for this cycle; CNT <= 0.
    - STOP=1: go to IDLE; Z_PULSE is still asserted this cycle.
    - RPT_LEFT==0: go to DONE.
    - otherwise: RPT_LEFT <= RPT_LEFT-1 and go to RUN.
  - DONE: DONE=1. If ACK=1, go to IDLE (DONE drops the next cycle); otherwise hold.
- Outputs are Moore-decoded from registered state: BUSY, DONE, Z_PULSE.
- Latency: START sampled at edge t gives
  - ARM during t..t+1;
  - RUN with CNT=0 from t+1;
  - first Z_PULSE in the cycle after edge t+2+CFG_VAL;
  - each repetition period of CFG_VAL+2 cycles (CFG_VAL+1 RUN cycles plus 1 MATCH cycle).
- Boundary conditions:
  - CFG_VAL=0 matches in the first RUN cycle; no increments occur.
  - CFG_VAL=2^WIDTH-1 counts the full range with no wrap before the match.
  - CFG_VAL and CFG_RPT changes after capture are ignored.
  - START outside IDLE is ignored.
  - START and STOP together in IDLE: the run starts; STOP is only acted on from ARM onward.
  - ACK outside DONE is ignored.
  - ACK together with STOP in DONE: go to IDLE.
- Counter: WIDTH/4 cascaded nibble slices.
  - Slice k increments when CNT_EN is high and all lower slices are 0xF.
  - Synchronous clear has priority over increment.

Decomposition:
- Shared package:
  - state enum (IDLE, ARM, RUN, MATCH, DONE) with fixed encodings 0-4;
  - NIBBLE=4 constant;
  - a width-check constant that asserts WIDTH%4==0.
- One sub-module, nibble_cnt: ports CK, RST, CLR, EN, CI, Q[3:0], CO.
  - CO = CI & (Q==4'hF).
  - Instantiated WIDTH/4 times in a chain, CI of slice 0 tied to CNT_EN.
- The FSM, compare and repeat logic stay in cnt_match_seq.

Test Plan:
- Reset: assert RST for 2 cycles after random traffic -> next cycle all outputs are 0 and the FSM is in IDLE.
- Single match: CFG_VAL=5, CFG_RPT=0, START one cycle.
  - Z_PULSE is high exactly once, in the cycle after edge t+7.
  - CNT sequence is 0,1,2,3,4,5.
  - DONE rises the next cycle and holds until ACK, then returns to IDLE.
- Repeats and nibble carries: CFG_VAL=16'h0011, CFG_RPT=2.
  - Three Z_PULSEs spaced 19 cycles apart.
  - RPT_LEFT goes 2, 1, 0.
  - CNT crosses 0x000F->0x0010, exercising the nibble carry.
- Edge values: CFG_VAL=0 -> Z_PULSE 3 cycles after the START edge. CFG_VAL=16'hFFFF -> match after 65536 RUN cycles, with the 0x0FFF->0x1000 carry checked.
- Abort: STOP at RUN with CNT=7 -> IDLE the next cycle, CNT holds 7, no Z_PULSE, no DONE. A new START with CFG_VAL=1 clears CNT to 0 and runs normally.
- Reset mid-run and priority:
  - RST asserted while in MATCH with STOP=1 -> IDLE with all outputs 0.
  - START while BUSY or in DONE -> ignored; the captured CFG_VAL is unchanged.
